vdp_sprite_line_readout: RTL and testbench

- Display-side reader of the sprite line buffers filled by vdp_sprite_draw.
- During active pixels 0–255 it reads each even/odd entry pair and presents one sprite colour per dot to the colour mixer.
- After consuming a pair it writes zero back to that pair, so the buffer is clean for the next draw pass.
- It owns the A/B bank-select bit that swaps draw and display buffers at line end.

---
 rtl/vdp_sprite_line_readout.sv | 119 +++++++++++
 tb/tb_vdp_sprite_line_readout.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vdp_sprite_line_readout.sv
// Display-side sprite line-buffer reader: one sprite colour per dot for pixels 0..255,
// clears each even/odd pair after use, and owns the draw/display bank-select bit.
module vdp_sprite_line_readout #(
  parameter int LINE_END = 341,
  parameter int X_ACTIVE = 256
) (
  input  logic       clk21m,
  input  logic       reset_n,
  input  logic [1:0] dot_state,
  input  logic [8:0] dot_counter_x,
  input  logic       reg_r8_col0_on,
  input  logic       sp_disp_en,
  output logic [6:0] lb_adr,
  output logic       lb_we,
  output logic [7:0] lb_wdata,
  input  logic [7:0] lb_xeven_q,
  input  logic [7:0] lb_xodd_q,
  output logic       lb_sel,
  output logic [3:0] sp_color,
  output logic       sp_color_en
);

  typedef enum logic [1:0] {
    PH_READ    = 2'b00,
    PH_CAPTURE = 2'b01,
    PH_OUTPUT  = 2'b11,
    PH_CLEAR   = 2'b10
  } phase_e;

  phase_e     phase;
  logic       in_win;
  logic       x_odd;
  logic [7:0] pix;
  logic       unused_pix_bits;

  logic [6:0] lb_adr_q, lb_adr_d;
  logic       lb_we_q, lb_we_d;
  logic       lb_sel_q, lb_sel_d;
  logic [3:0] sp_color_q, sp_color_d;
  logic       sp_color_en_q, sp_color_en_d;
  logic [7:0] pair_even_q, pair_even_d;
  logic [7:0] pair_odd_q, pair_odd_d;
  logic [1:0] ds_prev_q, ds_prev_d;

  assign phase  = phase_e'(dot_state);
  // Negative dots (-8..-1) have bit 8 set, so they fall outside the window too.
  assign in_win = !dot_counter_x[8] && (dot_counter_x < 9'(X_ACTIVE));
  assign x_odd  = dot_counter_x[0];
  assign pix    = x_odd ? pair_odd_q : pair_even_q;
  assign unused_pix_bits = ^pix[6:4];

  always_comb begin
    lb_adr_d      = lb_adr_q;
    lb_we_d       = 1'b0;
    lb_sel_d      = lb_sel_q;
    sp_color_d    = sp_color_q;
    sp_color_en_d = sp_color_en_q;
    pair_even_d   = pair_even_q;
    pair_odd_d    = pair_odd_q;
    ds_prev_d     = dot_state;

    case (phase)
      PH_READ: begin
        if (in_win && !x_odd) lb_adr_d = dot_counter_x[7:1];
      end
      PH_CAPTURE: begin
        if (in_win && !x_odd) begin
          pair_even_d = lb_xeven_q;
          pair_odd_d  = lb_xodd_q;
        end
      end
      PH_OUTPUT: begin
        if (in_win) begin
          sp_color_d    = pix[3:0];
          sp_color_en_d = sp_disp_en && pix[7] && ((pix[3:0] != 4'd0) || reg_r8_col0_on);
        end else begin
          sp_color_d    = 4'd0;
          sp_color_en_d = 1'b0;
        end
        if (dot_counter_x == 9'(LINE_END)) lb_sel_d = ~lb_sel_q;
      end
      PH_CLEAR: begin
        // Only the 11->10 transition may clear, so a stalled phase cannot stretch the pulse.
        lb_we_d = in_win && x_odd && (ds_prev_q == 2'b11);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk21m or negedge reset_n) begin
    if (!reset_n) begin
      lb_adr_q      <= 7'd0;
      lb_we_q       <= 1'b0;
      lb_sel_q      <= 1'b0;
      sp_color_q    <= 4'd0;
      sp_color_en_q <= 1'b0;
      pair_even_q   <= 8'd0;
      pair_odd_q    <= 8'd0;
      ds_prev_q     <= 2'b00;
    end else begin
      lb_adr_q      <= lb_adr_d;
      lb_we_q       <= lb_we_d;
      lb_sel_q      <= lb_sel_d;
      sp_color_q    <= sp_color_d;
      sp_color_en_q <= sp_color_en_d;
      pair_even_q   <= pair_even_d;
      pair_odd_q    <= pair_odd_d;
      ds_prev_q     <= ds_prev_d;
    end
  end

  assign lb_adr      = lb_adr_q;
  assign lb_we       = lb_we_q;
  assign lb_wdata    = 8'h00;
  assign lb_sel      = lb_sel_q;
  assign sp_color    = sp_color_q;
  assign sp_color_en = sp_color_en_q;

endmodule

// File: tb/tb_vdp_sprite_line_readout.sv
// Directed bench for vdp_sprite_line_readout: drives whole lines of dot timing against a
// display-bank memory model and checks readout, clears and bank swapping.
module tb_vdp_sprite_line_readout;

  localparam int LINE_END = 341;
  localparam int DOTS_PER_LINE = 350;

  logic       clk21m = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] dot_state = 2'b00;
  logic [8:0] dot_counter_x = 9'h1F8;
  logic       reg_r8_col0_on = 1'b0;
  logic       sp_disp_en = 1'b1;
  logic [6:0] lb_adr;
  logic       lb_we;
  logic [7:0] lb_wdata;
  logic [7:0] lb_xeven_q;
  logic [7:0] lb_xodd_q;
  logic       lb_sel;
  logic [3:0] sp_color;
  logic       sp_color_en;

  logic [7:0] mem_even [128];
  logic [7:0] mem_odd  [128];
  logic [7:0] snap_even [128];
  logic [7:0] snap_odd  [128];
  logic [3:0] obs_col [256];
  logic       obs_en  [256];
  logic [6:0] obs_adr [256];
  int         we_dot  [128];
  int         we_hits [128];

  int   vec_cnt = 0;
  int   miscmp = 0;
  int   phase = 0;
  int   we_cnt;
  int   sel_toggles;
  logic exp_sel = 1'b0;
  logic sel_prev = 1'b0;

  vdp_sprite_line_readout #(.LINE_END(LINE_END), .X_ACTIVE(256)) dut (
    .clk21m         (clk21m),
    .reset_n        (reset_n),
    .dot_state      (dot_state),
    .dot_counter_x  (dot_counter_x),
    .reg_r8_col0_on (reg_r8_col0_on),
    .sp_disp_en     (sp_disp_en),
    .lb_adr         (lb_adr),
    .lb_we          (lb_we),
    .lb_wdata       (lb_wdata),
    .lb_xeven_q     (lb_xeven_q),
    .lb_xodd_q      (lb_xodd_q),
    .lb_sel         (lb_sel),
    .sp_color       (sp_color),
    .sp_color_en    (sp_color_en)
  );

  // Display-bank read data is valid during the clock after the address is presented.
  assign lb_xeven_q = mem_even[lb_adr];
  assign lb_xodd_q  = mem_odd[lb_adr];

  always #23 clk21m = ~clk21m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miscmp++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ph2ds(input int p);
    case (p)
      0: return 2'b00;
      1: return 2'b01;
      2: return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 128; i++) begin
      mem_even[i] = v;
      mem_odd[i]  = v;
    end
  endtask

  // One clock: memory write-back, per-edge checks, then advance the dot timing.
  task automatic step();
    logic       we_pre;
    logic [6:0] adr_pre;
    logic [1:0] ds_pre;
    logic [8:0] x_pre;
    logic [7:0] p;
    logic       en_exp;
    we_pre  = lb_we;
    adr_pre = lb_adr;
    ds_pre  = dot_state;
    x_pre   = dot_counter_x;
    @(posedge clk21m);
    #1;
    if (we_pre) begin
      mem_even[adr_pre] = lb_wdata;
      mem_odd[adr_pre]  = lb_wdata;
    end
    if (reset_n) begin
      if (lb_we) begin
        we_cnt++;
        we_dot[lb_adr] = int'(x_pre);
        we_hits[lb_adr]++;
        chk("we_pos", 32'(ds_pre == 2'b10 && !x_pre[8] && x_pre[0]), 32'd1);
        chk("we_adr", 32'(lb_adr), 32'(x_pre[7:1]));
      end
      if (ds_pre == 2'b11 && x_pre == 9'(LINE_END)) exp_sel = ~exp_sel;
      if (lb_sel !== sel_prev) sel_toggles++;
      if (lb_sel !== sel_prev || (ds_pre == 2'b11 && x_pre == 9'(LINE_END)))
        chk("lb_sel", 32'(lb_sel), 32'(exp_sel));
      if (ds_pre == 2'b11) begin
        if (!x_pre[8]) begin
          p = x_pre[0] ? snap_odd[x_pre[7:1]] : snap_even[x_pre[7:1]];
          en_exp = sp_disp_en && p[7] && (p[3:0] != 4'd0 || reg_r8_col0_on);
          obs_col[x_pre[7:0]] = sp_color;
          obs_en[x_pre[7:0]]  = sp_color_en;
          obs_adr[x_pre[7:0]] = lb_adr;
          chk("pix_col", 32'(sp_color), 32'(p[3:0]));
          chk("pix_en", 32'(sp_color_en), 32'(en_exp));
        end else begin
          chk("idle_out", 32'({sp_color_en, sp_color}), 32'd0);
        end
      end
    end
    sel_prev = lb_sel;
    phase = (phase + 1) % 4;
    if (phase == 0) dot_counter_x = (dot_counter_x == 9'(LINE_END)) ? 9'h1F8 : dot_counter_x + 9'd1;
    dot_state = ph2ds(phase);
  endtask

  // Runs one full line from x=-8; rst_x >= 0 injects a reset at that dot's 01 phase.
  task automatic run_line(input string name, input int rst_x, input int exp_we, input int exp_dirty);
    int dirty;
    for (int i = 0; i < 128; i++) begin
      snap_even[i] = mem_even[i];
      snap_odd[i]  = mem_odd[i];
      we_dot[i]  = -1;
      we_hits[i] = 0;
    end
    for (int i = 0; i < 256; i++) begin
      obs_col[i] = 4'hX;
      obs_en[i]  = 1'bX;
      obs_adr[i] = 7'hX;
    end
    we_cnt = 0;
    sel_toggles = 0;
    for (int s = 0; s < DOTS_PER_LINE * 4; s++) begin
      step();
      if (rst_x >= 0 && reset_n && dot_counter_x == 9'(rst_x) && dot_state == 2'b01) begin
        #2 reset_n = 1'b0;
        #1;
        chk("rst_we", 32'(lb_we), 32'd0);
        chk("rst_en", 32'(sp_color_en), 32'd0);
        chk("rst_sel", 32'(lb_sel), 32'd0);
        chk("rst_adr", 32'(lb_adr), 32'd0);
        exp_sel = 1'b0;
      end
      if (rst_x >= 0 && !reset_n && dot_counter_x == 9'(rst_x + 2) && dot_state == 2'b00) begin
        reset_n = 1'b1;
        sel_prev = lb_sel;
      end
    end
    dirty = 0;
    for (int i = 0; i < 128; i++) if (mem_even[i] != 8'd0 || mem_odd[i] != 8'd0) dirty++;
    chk("we_count", 32'(we_cnt), 32'(exp_we));
    chk("dirty_pairs", 32'(dirty), 32'(exp_dirty));
    chk("sel_toggles", 32'(sel_toggles), 32'd1);
    $display("line %-10s : clears=%0d dirty=%0d lb_sel=%0b", name, we_cnt, dirty, lb_sel);
  endtask

  initial begin
    int en_ones;
    fill(8'h00);
    reset_n = 1'b0;
    for (int i = 0; i < 50; i++) @(posedge clk21m);
    #1;
    chk("reset_adr", 32'(lb_adr), 32'd0);
    chk("reset_we", 32'(lb_we), 32'd0);
    chk("reset_sel", 32'(lb_sel), 32'd0);
    chk("reset_col", 32'(sp_color), 32'd0);
    chk("reset_en", 32'(sp_color_en), 32'd0);
    chk("reset_wdata", 32'(lb_wdata), 32'd0);
    reset_n = 1'b1;
    sel_prev = lb_sel;
    exp_sel = 1'b0;

    run_line("reset", -1, 128, 0);
    chk("sel_after_line", 32'(lb_sel), 32'd1);

    fill(8'h00);
    mem_even[5] = 8'h87;
    mem_odd[5]  = 8'h8F;
    sp_disp_en = 1'b1;
    reg_r8_col0_on = 1'b0;
    run_line("readout", -1, 128, 0);
    chk("px10_col", 32'(obs_col[10]), 32'd7);
    chk("px10_en", 32'(obs_en[10]), 32'd1);
    chk("px11_col", 32'(obs_col[11]), 32'd15);
    chk("px11_en", 32'(obs_en[11]), 32'd1);
    chk("px10_adr", 32'(obs_adr[10]), 32'd5);
    chk("px11_adr", 32'(obs_adr[11]), 32'd5);
    chk("pair5_we_dot", 32'(we_dot[5]), 32'd11);
    chk("pair5_we_hits", 32'(we_hits[5]), 32'd1);

    fill(8'h00);
    mem_even[0] = 8'h80;
    mem_odd[0]  = 8'h00;
    reg_r8_col0_on = 1'b0;
    run_line("col0_off", -1, 128, 0);
    chk("c0off_x0_en", 32'(obs_en[0]), 32'd0);
    chk("c0off_x1_en", 32'(obs_en[1]), 32'd0);

    mem_even[0] = 8'h80;
    mem_odd[0]  = 8'h00;
    reg_r8_col0_on = 1'b1;
    run_line("col0_on", -1, 128, 0);
    chk("c0on_x0_en", 32'(obs_en[0]), 32'd1);
    chk("c0on_x0_col", 32'(obs_col[0]), 32'd0);
    chk("c0on_x1_en", 32'(obs_en[1]), 32'd0);
    reg_r8_col0_on = 1'b0;

    fill(8'hFF);
    run_line("clear_all", -1, 128, 0);
    for (int a = 0; a < 128; a++) begin
      chk("clear_hits", 32'(we_hits[a]), 32'd1);
      chk("clear_dot", 32'(we_dot[a]), 32'(2 * a + 1));
    end

    fill(8'hFF);
    run_line("mid_reset", 100, 127, 1);
    chk("midrst_pair50", 32'(mem_even[50]), 32'hFF);
    chk("midrst_px102_en", 32'(obs_en[102]), 32'd1);
    chk("midrst_px102_adr", 32'(obs_adr[102]), 32'd51);

    fill(8'hFF);
    sp_disp_en = 1'b0;
    run_line("disabled", -1, 128, 0);
    en_ones = 0;
    for (int i = 0; i < 256; i++) if (obs_en[i] !== 1'b0) en_ones++;
    chk("disabled_en", 32'(en_ones), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end

endmodule
